// File: rtl/parity_merge_pkg.sv
// Shared types and helpers for the parity stream merger: arbiter states,
// source tags and a width-agnostic parity function.
package parity_merge_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GRANT_EVEN = 2'd1,
        GRANT_ODD  = 2'd2
    } arb_state_t;

    localparam logic SRC_EVEN = 1'b0;
    localparam logic SRC_ODD  = 1'b1;

    // Callers zero-extend their data, which leaves the XOR reduction unchanged.
    function automatic logic xor_parity(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/merge_byte_fifo.sv
// Show-ahead synchronous FIFO with async active-high reset; set_last marks the
// most recently written entry as end of packet.
module merge_byte_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     set_last,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] last_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign last_ptr = wr_ptr - PTR_W'(1);
    assign rd_data  = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end else if (set_last && !empty) begin
            mem[last_ptr][WIDTH-1] <= 1'b1;
        end
    end

endmodule

// File: rtl/parity_stream_merger.sv
// Merges the even- and odd-parity AXI-Stream byte outputs of the parity filter
// into one stream, packet-interleaved, tagged on tuser. Optional check: PARITY_MERGE_CHECK_EN.
import parity_merge_pkg::*;

module parity_stream_merger #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic              a_clk,
    input  logic              axis_aresetn,
    input  logic              axis_s_tvalid_even,
    input  logic [DATA_W-1:0] axis_s_tdata_even,
    input  logic              axis_s_tlast_even,
    output logic              axis_s_tready_even,
    input  logic              axis_s_tvalid_odd,
    input  logic [DATA_W-1:0] axis_s_tdata_odd,
    input  logic              axis_s_tlast_odd,
    output logic              axis_s_tready_odd,
    output logic              axis_m_tvalid,
    output logic [DATA_W-1:0] axis_m_tdata,
    output logic              axis_m_tlast,
    output logic              axis_m_tuser,
    input  logic              axis_m_tready,
    output logic [CNT_W-1:0]  parity_err_cnt
);
    localparam int FW = DATA_W + 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    function automatic arb_state_t grant_of(input logic src);
        return src ? GRANT_ODD : GRANT_EVEN;
    endfunction

    logic          rst;
    logic          even_acc, odd_acc, even_push, odd_push;
    logic          even_set_last, odd_set_last;
    logic          even_full, even_empty, odd_full, odd_empty;
    logic          even_pop, odd_pop;
    logic [CW-1:0] even_count, odd_count;
    logic [FW-1:0] even_rd, odd_rd, sel_data;
    arb_state_t    state;
    logic          last_grant, sel, avail, load;
    logic          popped_last, other_ready, sel_more;

    // Legacy port name; the reset is active-high.
    assign rst = axis_aresetn;

    assign axis_s_tready_even = !even_full;
    assign axis_s_tready_odd  = !odd_full;
    assign even_acc = axis_s_tvalid_even && axis_s_tready_even;
    assign odd_acc  = axis_s_tvalid_odd && axis_s_tready_odd;

`ifdef PARITY_MERGE_CHECK_EN
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W+1)'(b);
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    logic       even_drop, odd_drop;
    logic [1:0] n_drop;

    assign even_drop     = even_acc && (xor_parity(64'(axis_s_tdata_even)) != 1'b0);
    assign odd_drop      = odd_acc && (xor_parity(64'(axis_s_tdata_odd)) != 1'b1);
    assign n_drop        = {1'b0, even_drop} + {1'b0, odd_drop};
    assign even_push     = even_acc && !even_drop;
    assign odd_push      = odd_acc && !odd_drop;
    // A dropped end-of-packet byte still closes the packet already buffered.
    assign even_set_last = even_drop && axis_s_tlast_even;
    assign odd_set_last  = odd_drop && axis_s_tlast_odd;

    always_ff @(posedge a_clk or posedge rst) begin
        if (rst) begin
            parity_err_cnt <= '0;
        end else if (n_drop != 2'd0) begin
            parity_err_cnt <= sat_add(parity_err_cnt, n_drop);
        end
    end
`else
    assign even_push      = even_acc;
    assign odd_push       = odd_acc;
    assign even_set_last  = 1'b0;
    assign odd_set_last   = 1'b0;
    assign parity_err_cnt = '0;
`endif

    merge_byte_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_even_fifo (
        .clk(a_clk), .rst(rst),
        .push(even_push), .push_data({axis_s_tlast_even, axis_s_tdata_even}),
        .set_last(even_set_last), .pop(even_pop), .rd_data(even_rd),
        .full(even_full), .empty(even_empty), .count(even_count)
    );

    merge_byte_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_odd_fifo (
        .clk(a_clk), .rst(rst),
        .push(odd_push), .push_data({axis_s_tlast_odd, axis_s_tdata_odd}),
        .set_last(odd_set_last), .pop(odd_pop), .rd_data(odd_rd),
        .full(odd_full), .empty(odd_empty), .count(odd_count)
    );

    // IDLE decides and pops in the same cycle; a granted side is held until its tlast.
    always_comb begin
        sel   = SRC_EVEN;
        avail = 1'b0;
        case (state)
            GRANT_EVEN: begin
                sel   = SRC_EVEN;
                avail = !even_empty;
            end
            GRANT_ODD: begin
                sel   = SRC_ODD;
                avail = !odd_empty;
            end
            default: begin
                avail = !even_empty || !odd_empty;
                if (!even_empty && !odd_empty) sel = !last_grant;
                else                           sel = even_empty ? SRC_ODD : SRC_EVEN;
            end
        endcase
    end

    assign load        = avail && (!axis_m_tvalid || axis_m_tready);
    assign sel_data    = sel ? odd_rd : even_rd;
    assign even_pop    = load && (sel == SRC_EVEN);
    assign odd_pop     = load && (sel == SRC_ODD);
    assign popped_last = sel_data[DATA_W];
    assign other_ready = sel ? !even_empty : !odd_empty;
    assign sel_more    = sel ? (odd_count > CW'(1)) : (even_count > CW'(1));

    always_ff @(posedge a_clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= SRC_ODD;
        end else if (load) begin
            if (popped_last) begin
                last_grant <= sel;
                if (other_ready)   state <= grant_of(!sel);
                else if (sel_more) state <= grant_of(sel);
                else               state <= IDLE;
            end else begin
                state <= grant_of(sel);
            end
        end
    end

    // ---- output register stage ----
    always_ff @(posedge a_clk or posedge rst) begin
        if (rst) begin
            axis_m_tvalid <= 1'b0;
            axis_m_tdata  <= '0;
            axis_m_tlast  <= 1'b0;
            axis_m_tuser  <= 1'b0;
        end else if (load) begin
            axis_m_tvalid <= 1'b1;
            axis_m_tdata  <= sel_data[DATA_W-1:0];
            axis_m_tlast  <= popped_last;
            axis_m_tuser  <= sel;
        end else if (axis_m_tready) begin
            axis_m_tvalid <= 1'b0;
        end
    end

endmodule

// File: doc/parity_stream_merger.md
Name: parity_stream_merger

Overview:
- Downstream stage of the parity filter. Consumes its two AXI-Stream byte outputs (even-parity and odd-parity) and merges them into one AXI-Stream byte output.
- Each input is buffered in a small FIFO.
- A packet-locked round-robin arbiter interleaves whole packets, delimited by tlast.
- Each output byte is tagged with its source parity on tuser.

Parameters:
- DATA_W, 8, byte width of all data ports.
- FIFO_DEPTH, 8, entries per input FIFO; power of two, minimum 2.
- CNT_W, 16, width of the error counter.

Ports:
- a_clk  input  1  sole clock; all logic on rising edge.
- axis_aresetn  input  1  asynchronous, active-high reset (asserted = 1), despite the legacy name.
- axis_s_tvalid_even  input  1  even-stream valid.
- axis_s_tdata_even  input  DATA_W  even-stream data.
- axis_s_tlast_even  input  1  even-stream end of packet.
- axis_s_tready_even  output  1  even-stream ready; equals even FIFO not full.
- axis_s_tvalid_odd  input  1  odd-stream valid.
- axis_s_tdata_odd  input  DATA_W  odd-stream data.
- axis_s_tlast_odd  input  1  odd-stream end of packet.
- axis_s_tready_odd  output  1  odd-stream ready; equals odd FIFO not full.
- axis_m_tvalid  output  1  merged output valid.
- axis_m_tdata  output  DATA_W  merged output data.
- axis_m_tlast  output  1  merged output end of packet.
- axis_m_tuser  output  1  source tag: 0 = even, 1 = odd.
- axis_m_tready  input  1  downstream ready.
- parity_err_cnt  output  CNT_W  count of dropped mismatched bytes; saturating.

Behaviour:
- Clocking and reset:
  - One clock. Reset is asynchronous and active-high.
  - On reset, all of these are 0: FIFO pointers and counts, axis_m_tvalid, axis_m_tdata, axis_m_tlast, axis_m_tuser, parity_err_cnt.
  - Arbiter returns to IDLE and last_grant resets to ODD, so EVEN has first priority.
  - Reset mid-packet discards all buffered bytes and any partially sent packet. No tlast is emitted for that packet.
- Input side:
  - A transfer occurs when tvalid && tready. The byte and tlast are written to that input's FIFO on that edge.
  - tready = !full. It is combinational from the registered count and never depends on tvalid.
  - A push and pop in the same cycle leaves the count unchanged. This is legal even at full-1 and at 1 entry.
  - Pointers wrap modulo FIFO_DEPTH.
- Output register:
  - Single-stage registered output.
  - It loads when (!axis_m_tvalid || axis_m_tready) and the granted FIFO is non-empty.
  - axis_m_tvalid and all payload fields hold stable while tvalid && !tready.
- Arbiter FSM (states IDLE, GRANT_EVEN, GRANT_ODD):
  - IDLE, one FIFO non-empty: grant that FIFO.
  - IDLE, both non-empty: grant the side opposite last_grant.
  - The grant decision and the first pop occur in the same cycle, with no dead cycle.
  - GRANT_x: pop one byte from FIFO x per output load.
  - When the popped byte has tlast = 1: set last_grant = x. Next state is GRANT of the other side if that side is non-empty; else GRANT_x if x is non-empty; else IDLE.
  - GRANT_x with FIFO x empty mid-packet: hold the grant and stall. Never switch mid-packet.
- Latency:
  - Input byte accepted at edge N, both FIFOs previously empty, downstream ready: appears on axis_m_tvalid after edge N+1.
  - Sustained throughput is 1 byte/cycle.
- tuser equals the granted side for every byte of the packet.

Optional Feature:
- Macro PARITY_MERGE_CHECK_EN.
- Defined:
  - Each input byte's XOR-reduced parity is checked against its port (even port requires parity 0, odd port requires parity 1).
  - A mismatched byte is accepted (tready unaffected) but not written to the FIFO.
  - parity_err_cnt increments by 1, or by 2 if both ports mismatch in the same cycle, saturating at all-ones.
  - If a dropped byte carried tlast, the tlast is transferred onto the previous FIFO entry if one exists. Otherwise it is discarded.
- Undefined: no check is performed and parity_err_cnt is tied to 0.

Decomposition:
- Package parity_merge_pkg holds:
  - arb_state_t enum (IDLE, GRANT_EVEN, GRANT_ODD).
  - Localparams SRC_EVEN = 1'b0, SRC_ODD = 1'b1.
  - A parity function.
- Sub-module merge_byte_fifo, instantiated twice:
  - Synchronous FIFO with async active-high reset.
  - Width DATA_W+1 (data plus tlast).
  - Outputs full, empty, and registered count; show-ahead read data.

Test Plan:
- Even packet 0x03, 0x05, 0x06 (tlast on 0x06) only, tready = 1: output 0x03, 0x05, 0x06 with tuser = 0, tlast on the third byte, first valid 2 edges after the first input.
- Both FIFOs preloaded simultaneously with even {0x00, 0x11(last)} and odd {0x01, 0x07(last)}: output order 0x00, 0x11, 0x01, 0x07 with tuser 0, 0, 1, 1 (EVEN first after reset).
- Odd packet stalled mid-packet (FIFO empty after 0x01, no tlast yet) while even has data: no even byte is emitted until odd tlast 0x02 arrives. Check tuser never toggles mid-packet.
- axis_m_tready = 0 for 20 cycles with FIFO_DEPTH = 8 and both inputs streaming: each tready drops after 8 accepts plus 1 held in the output register. Output holds stable, no bytes are lost, order is preserved after release.
- Assert reset for 1 cycle asynchronously (between edges) mid-packet: outputs go to 0 immediately, both tready = 1 on the next cycle, and a new even packet after reset is emitted first.
- With PARITY_MERGE_CHECK_EN, feed 0x03 on the odd port and 0x01 on the even port in the same cycle: both are dropped, parity_err_cnt = 2, and no output is produced.
